pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard/stall controller for the 5-stage MIPS pipeline; successor to the single-cycle combinational hazard unit.
- Adds multi-cycle load-use stalls (configurable load latency) and per-register JR/JALR source checking instead of a global "any write pending" stall.
- Adds branch-taken flush and sticky halt.
- Drives PC, IF/ID and control-bubble enables from the ID stage.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_LAT, 1, load-use stall cycles (1..7).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  REG_ADDR_W  ID source register rs.
- id_rt  in  REG_ADDR_W  ID source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_jr  in  1  ID instruction is JR/JALR (reads rs in ID).
- ex_rd  in  REG_ADDR_W  EX destination register.
- ex_wr_en  in  1  EX writes a register.
- ex_is_load  in  1  EX instruction is a load.
- mem_rd  in  REG_ADDR_W  MEM destination register.
- mem_wr_en  in  1  MEM writes a register.
- wb_rd  in  REG_ADDR_W  WB destination register.
- wb_wr_en  in  1  WB writes a register.
- branch_taken  in  1  branch/jump resolved taken this cycle.
- fin  in  1  end-of-program request.
- pc_en  out  1  PC update enable.
- if_en  out  1  IF/ID register enable.
- ctrl_en  out  1  0 = inject bubble into ID/EX.
- if_flush  out  1  clear IF/ID to NOP.
- halted  out  1  HALT state active.
- stall_cycles  out  CNT_W  stall counter (see Optional Feature).

Behaviour:
- Reset: held synchronously; state=RUN, cnt=0, stall_cycles=0. While reset=1 the outputs are pc_en=1, if_en=1, ctrl_en=1, if_flush=0, halted=0.
- Match rule: match(a,r,we) = we && r!=0 && a==r. Register $0 never causes a hazard.
- load_hz = ex_is_load && (match(id_rs,ex_rd,ex_wr_en) || (id_uses_rt && match(id_rt,ex_rd,ex_wr_en))).
- jr_hz = id_is_jr && (match(id_rs,ex_rd,ex_wr_en) || match(id_rs,mem_rd,mem_wr_en) || match(id_rs,wb_rd,wb_wr_en)).
- States: RUN, LOAD_STALL, JR_WAIT, HALT. Hazard detection is Mealy: the stall is asserted in the same cycle it is detected.
- Stall outputs: pc_en=0, if_en=0, ctrl_en=0, if_flush=0.
- Priority per cycle: reset > HALT/fin > branch_taken > load stall > jr stall > run.
- fin=1 (any state): stall outputs this cycle; next state HALT. HALT is sticky until reset, with stall outputs and halted=1.
- branch_taken=1 (not halted): pc_en=1, if_en=1, if_flush=1, ctrl_en=0; next state RUN, cnt=0. The flush cancels any pending load or JR stall.
- RUN, load_hz: stall. If LOAD_LAT>1, go to LOAD_STALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
- LOAD_STALL: stall. cnt decrements; when cnt reaches 1, the next state is RUN. Load inputs are ignored in this state.
- RUN, jr_hz (no load_hz): stall; go to JR_WAIT.
- JR_WAIT: stall while jr_hz; when jr_hz=0, drive run outputs the same cycle and go to RUN.
- RUN, no hazard: pc_en=1, if_en=1, ctrl_en=1, if_flush=0.
- Reset mid-stall or in HALT: next cycle is RUN with cnt=0.

Optional Feature:
- HAZARD_PERF_EN defined: stall_cycles increments on every cycle with pc_en=0 and state!=HALT (fin cycle included). It saturates at all-ones and is cleared by reset.
- HAZARD_PERF_EN undefined: stall_cycles is tied to 0 and the counter logic is absent.

Decomposition:
- hazard_pkg: state enum (RUN, LOAD_STALL, JR_WAIT, HALT), REG_ZERO constant, and the LOAD_LAT legal-range check.
- One sub-module, hazard_reg_match (a, r, we -> hit, with $0 suppression), instantiated 5 times.

Test Plan:
- LOAD_LAT=1: ex_is_load, ex_wr_en=1, ex_rd=5, id_rs=5 -> 1 cycle pc_en=if_en=ctrl_en=0, then all 1. With ex_rd=0 -> no stall.
- LOAD_LAT=3: same load-use -> exactly 3 consecutive stall cycles; stall_cycles=3 with HAZARD_PERF_EN.
- id_is_jr, id_rs=31, writer to 31 moving EX->MEM->WB -> stall 3 cycles, release the cycle wb_wr_en drops. A writer to 30 -> no stall.
- LOAD_LAT=3 stall in progress, branch_taken=1 in the 2nd stall cycle -> that cycle if_flush=1, pc_en=1, ctrl_en=0; the next cycle is RUN.
- fin=1 for one cycle -> all enables 0 and halted=1 indefinitely; reset -> enables 1, halted=0, stall_cycles=0.
- id_uses_rt=0, id_rt=ex_rd=7 (load) -> no stall. With id_uses_rt=1 -> stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    JR_WAIT    = 2'd2,
    HALT       = 2'd3
  } hz_state_e;

  localparam int unsigned REG_ZERO     = 0;
  localparam int          LOAD_LAT_MIN = 1;
  localparam int          LOAD_LAT_MAX = 7;
  localparam int          LCNT_W       = 3;

  function automatic bit load_lat_ok(input int lat);
    return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
  endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Register-index compare with write-enable; register $0 never matches.
module hazard_reg_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_a,
  input  logic [REG_ADDR_W-1:0] i_r,
  input  logic                  i_we,
  output logic                  o_hit
);

  assign o_hit = i_we && (i_r != REG_ADDR_W'(REG_ZERO)) && (i_a == i_r);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / JR hazard stall controller with branch flush and sticky halt.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
//
// state      | meaning
// RUN        | normal issue; detects load-use and JR hazards
// LOAD_STALL | extra load-use stall cycles, counted down in r_cnt
// JR_WAIT    | JR/JALR waiting for its rs writer to retire
// HALT       | program finished; stalled until reset
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_is_jr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wr_en,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wr_en,
  input  logic                  branch_taken,
  input  logic                  fin,
  output logic                  pc_en,
  output logic                  if_en,
  output logic                  ctrl_en,
  output logic                  if_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles
);

  if (!load_lat_ok(LOAD_LAT)) begin : g_bad_load_lat
    $error("pipeline_hazard_ctrl: LOAD_LAT must be in 1..7");
  end

  hz_state_e          r_state;
  hz_state_e          w_state_nxt;
  logic [LCNT_W-1:0]  r_cnt;
  logic [LCNT_W-1:0]  w_cnt_nxt;

  logic w_ld_rs_hit, w_ld_rt_hit, w_jr_ex_hit, w_jr_mem_hit, w_jr_wb_hit;
  logic w_load_hz, w_jr_hz;

  // Load compares are gated by ex_is_load so the EX-stage JR compare stays independent.
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_ld_rs (
    .i_a(id_rs), .i_r(ex_rd), .i_we(ex_wr_en && ex_is_load), .o_hit(w_ld_rs_hit));
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_ld_rt (
    .i_a(id_rt), .i_r(ex_rd), .i_we(ex_wr_en && ex_is_load && id_uses_rt), .o_hit(w_ld_rt_hit));
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_jr_ex (
    .i_a(id_rs), .i_r(ex_rd), .i_we(ex_wr_en), .o_hit(w_jr_ex_hit));
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_jr_mem (
    .i_a(id_rs), .i_r(mem_rd), .i_we(mem_wr_en), .o_hit(w_jr_mem_hit));
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_jr_wb (
    .i_a(id_rs), .i_r(wb_rd), .i_we(wb_wr_en), .o_hit(w_jr_wb_hit));

  assign w_load_hz = w_ld_rs_hit || w_ld_rt_hit;
  assign w_jr_hz   = id_is_jr && (w_jr_ex_hit || w_jr_mem_hit || w_jr_wb_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_en       = 1'b1;
    if_en       = 1'b1;
    ctrl_en     = 1'b1;
    if_flush    = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == HALT || fin) begin
      pc_en       = 1'b0;
      if_en       = 1'b0;
      ctrl_en     = 1'b0;
      halted      = (r_state == HALT);
      w_state_nxt = HALT;
    end else if (branch_taken) begin
      ctrl_en     = 1'b0;
      if_flush    = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_load_hz) begin
            pc_en   = 1'b0;
            if_en   = 1'b0;
            ctrl_en = 1'b0;
            if (LOAD_LAT > 1) begin
              w_state_nxt = LOAD_STALL;
              w_cnt_nxt   = LCNT_W'(LOAD_LAT - 1);
            end
          end else if (w_jr_hz) begin
            pc_en       = 1'b0;
            if_en       = 1'b0;
            ctrl_en     = 1'b0;
            w_state_nxt = JR_WAIT;
          end
        end
        LOAD_STALL: begin
          pc_en   = 1'b0;
          if_en   = 1'b0;
          ctrl_en = 1'b0;
          if (r_cnt <= LCNT_W'(1)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - LCNT_W'(1);
          end
        end
        JR_WAIT: begin
          if (w_jr_hz) begin
            pc_en   = 1'b0;
            if_en   = 1'b0;
            ctrl_en = 1'b0;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_stall_evt;

  assign w_stall_evt = !pc_en && (r_state != HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall_evt && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: two controllers (LOAD_LAT=1 and 3) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, if_en, ctrl_en, if_flush, halted}
  localparam logic [4:0] RN = 5'b11100;
  localparam logic [4:0] ST = 5'b00000;
  localparam logic [4:0] FL = 5'b11010;
  localparam logic [4:0] HT = 5'b00001;

  typedef struct {
    logic [4:0]  e1;
    logic [4:0]  e3;
    bit          chk;
    logic [31:0] c1;
    logic [31:0] c3;
    int          id;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rt, id_is_jr, ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic        branch_taken, fin;

  logic        pc_en1, if_en1, ctrl_en1, if_flush1, halted1;
  logic        pc_en3, if_en3, ctrl_en3, if_flush3, halted3;
  logic [31:0] cnt1, cnt3;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_jr(id_is_jr), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
    .branch_taken(branch_taken), .fin(fin), .pc_en(pc_en1), .if_en(if_en1),
    .ctrl_en(ctrl_en1), .if_flush(if_flush1), .halted(halted1), .stall_cycles(cnt1));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_jr(id_is_jr), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
    .branch_taken(branch_taken), .fin(fin), .pc_en(pc_en3), .if_en(if_en3),
    .ctrl_en(ctrl_en3), .if_flush(if_flush3), .halted(halted3), .stall_cycles(cnt3));

  wire [4:0] o1 = {pc_en1, if_en1, ctrl_en1, if_flush1, halted1};
  wire [4:0] o3 = {pc_en3, if_en3, ctrl_en3, if_flush3, halted3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      n_checks++;
      assert (o1 === cur.e1) else begin
        n_errors++;
        $error("FAIL out_lat1 step=%0d got=%b exp=%b", cur.id, o1, cur.e1);
      end
      n_checks++;
      assert (o3 === cur.e3) else begin
        n_errors++;
        $error("FAIL out_lat3 step=%0d got=%b exp=%b", cur.id, o3, cur.e3);
      end
      if (cur.chk) begin
        n_checks++;
        assert (cnt1 === cur.c1) else begin
          n_errors++;
          $error("FAIL cnt_lat1 step=%0d got=%0d exp=%0d", cur.id, cnt1, cur.c1);
        end
        n_checks++;
        assert (cnt3 === cur.c3) else begin
          n_errors++;
          $error("FAIL cnt_lat3 step=%0d got=%0d exp=%0d", cur.id, cnt3, cur.c3);
        end
      end
    end
  end

  task automatic clr();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_jr = 1'b0;
    ex_rd = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_rd = '0; mem_wr_en = 1'b0; wb_rd = '0; wb_wr_en = 1'b0;
    branch_taken = 1'b0; fin = 1'b0;
  endtask

  task automatic push(input logic [4:0] e1, input logic [4:0] e3, input bit chk,
                      input int c1, input int c3);
    exp_t e;
    e.e1 = e1; e.e3 = e3; e.chk = chk; e.id = step_id;
    e.c1 = PERF ? 32'(c1) : 32'd0;
    e.c3 = PERF ? 32'(c3) : 32'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
    step_id++;
  endtask

  task automatic nxt(input logic [4:0] e1, input logic [4:0] e3);
    push(e1, e3, 1'b0, 0, 0);
  endtask

  task automatic nxtc(input logic [4:0] e1, input logic [4:0] e3, input int c1, input int c3);
    push(e1, e3, 1'b1, c1, c3);
  endtask

  task automatic load_use5();
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk);
    #1;
    nxtc(RN, RN, 0, 0);
    nxt(RN, RN);
    reset = 1'b0;

    // load-use on rs: 1 stall for LOAD_LAT=1, 3 for LOAD_LAT=3
    load_use5();
    nxt(ST, ST);
    clr();
    nxt(RN, ST);
    nxt(RN, ST);
    nxtc(RN, RN, 1, 3);
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    nxt(RN, RN);

    // rt only counts when the instruction reads rt
    clr();
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
    nxt(RN, RN);
    id_uses_rt = 1'b1;
    nxt(ST, ST);
    clr();
    nxt(RN, ST);
    nxt(RN, ST);
    nxtc(RN, RN, 2, 6);

    // JR on r31 while the writer walks EX -> MEM -> WB
    id_is_jr = 1'b1; id_rs = 5'd31; ex_rd = 5'd31; ex_wr_en = 1'b1;
    nxt(ST, ST);
    ex_wr_en = 1'b0; ex_rd = 5'd0; mem_rd = 5'd31; mem_wr_en = 1'b1;
    nxt(ST, ST);
    mem_wr_en = 1'b0; mem_rd = 5'd0; wb_rd = 5'd31; wb_wr_en = 1'b1;
    nxt(ST, ST);
    wb_wr_en = 1'b0; wb_rd = 5'd0;
    nxt(RN, RN);
    ex_rd = 5'd30; ex_wr_en = 1'b1;
    nxt(RN, RN);
    clr();
    nxtc(RN, RN, 5, 9);

    // branch taken in the second load stall cycle cancels the stall
    load_use5();
    nxt(ST, ST);
    clr();
    branch_taken = 1'b1;
    nxt(FL, FL);
    branch_taken = 1'b0;
    nxtc(RN, RN, 6, 10);

    // fin during a load stall, then sticky halt ignoring branch and load
    load_use5();
    nxt(ST, ST);
    clr();
    fin = 1'b1;
    nxt(ST, ST);
    fin = 1'b0;
    nxt(HT, HT);
    branch_taken = 1'b1;
    nxt(HT, HT);
    clr();
    load_use5();
    nxtc(HT, HT, 8, 12);
    clr();
    reset = 1'b1;
    nxt(RN, RN);
    reset = 1'b0;
    nxtc(RN, RN, 0, 0);

    // fin from RUN
    fin = 1'b1;
    nxt(ST, ST);
    fin = 1'b0;
    nxt(HT, HT);
    nxt(HT, HT);
    nxtc(HT, HT, 1, 1);
    reset = 1'b1;
    nxt(RN, RN);
    reset = 1'b0;
    nxtc(RN, RN, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
